// File: rtl/iter_shift_unit_pkg.sv
// Shared encodings for the iterative shift unit: op codes and FSM states.
// The ALU decoder imports the same package so both ends agree on op encoding.
package iter_shift_unit_pkg;

  typedef enum logic [1:0] {
    OpSll = 2'b00,
    OpSrl = 2'b01,
    OpSra = 2'b10,
    OpRol = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

endpackage

// File: rtl/iter_shift_unit_shift_step1.sv
// Combinational single-bit shift/rotate step used once per SHIFT cycle.
module iter_shift_unit_shift_step1
  import iter_shift_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = s;
    unique case (op)
      OpSll:   y = {s[WIDTH-2:0], 1'b0};
      OpSrl:   y = {1'b0, s[WIDTH-1:1]};
      OpSra:   y = {s[WIDTH-1], s[WIDTH-1:1]};
      OpRol:   y = {s[WIDTH-2:0], s[WIDTH-1]};
      default: y = s;
    endcase
  end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift/rotate engine: one bit per clock, start/busy/done handshake.
// Result register holds its value until the next accepted start.
module iter_shift_unit
  import iter_shift_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_e           state_q;
  op_e              op_q;
  logic [AMT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] step_y;

  iter_shift_unit_shift_step1 #(
    .WIDTH (WIDTH)
  ) u_step (
    .op (op_q),
    .s  (sreg_q),
    .y  (step_y)
  );

  // busy/done are registered alongside the state so no output depends on inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= OpSll;
      cnt_q   <= '0;
      sreg_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            sreg_q <= data;
            op_q   <= op_e'(op);
            cnt_q  <= shamt;
            if (shamt != '0) begin
              state_q <= StShift;
              busy    <= 1'b1;
              done    <= 1'b0;
            end else begin
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b0;
          end
        end
        StShift: begin
          sreg_q <= step_y;
          cnt_q  <= cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  assign result = sreg_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed and randomized checks of iter_shift_unit against an arithmetic reference.
module tb_iter_shift_unit;

  localparam int W = 16;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] data = '0;
  logic [A-1:0] shamt = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  iter_shift_unit #(
    .WIDTH (W),
    .AMT_W (A)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .data   (data),
    .shamt  (shamt),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Whole-operand reference: shift by the full amount in one go.
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] d,
                                         input int sa);
    logic signed [W-1:0] sd;
    logic [2*W-1:0]      dd;
    int                  k;
    sd = d;
    case (o)
      2'b00:   model = W'(d << sa);
      2'b01:   model = d >> sa;
      2'b10:   model = sd >>> sa;
      default: begin
        k  = sa % W;
        dd = {d, d} << k;
        model = dd[2*W-1:W];
      end
    endcase
  endfunction

  // Called at #1 after an edge with the unit idle or in its done cycle. Returns in the
  // done cycle of this op. Latency counts edges after the accepting edge until done.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] d, input logic [A-1:0] sa,
                        input bit junk, input logic [W-1:0] exp_res, input string tag);
    int n;
    start = 1'b1;
    op    = o;
    data  = d;
    shamt = sa;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (junk) begin
        start = 1'($urandom);
        op    = 2'($urandom);
        data  = W'($urandom);
        shamt = A'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(n), 32'(sa));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] rd;
    logic [A-1:0] rs;
    bit           saw_done;

    // Reset state
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    #15 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op(2'b00, 16'h00F1, 4'd4, 1'b0, 16'h0F10, "sll4");
    @(posedge clk); #1;
    chk("hold_done", 32'(done), 32'd0);
    chk("hold_result", 32'(result), 32'h0F10);
    run_op(2'b10, 16'h8004, 4'd2, 1'b0, 16'hE001, "sra2");
    run_op(2'b01, 16'h8004, 4'd2, 1'b0, 16'h2001, "srl2");
    run_op(2'b11, 16'h8001, 4'd15, 1'b0, 16'hC000, "rol15");
    run_op(2'b11, 16'h8001, 4'd0, 1'b0, 16'h8001, "rol0");

    // Starts while busy are ignored; then back-to-back start in the done cycle.
    run_op(2'b00, 16'h00F1, 4'd4, 1'b1, 16'h0F10, "ign");
    run_op(2'b01, 16'h8004, 4'd1, 1'b0, 16'h4002, "b2b");
    @(posedge clk); #1;
    chk("b2b_drop", 32'(done), 32'd0);

    // Async reset in the middle of a shift
    start = 1'b1; op = 2'b00; data = 16'hABCD; shamt = 4'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_result", 32'(result), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("arst_no_done", 32'(saw_done), 32'd0);
    run_op(2'b10, 16'h9234, 4'd3, 1'b0, 16'hF246, "post_rst");

    // Randomized ops, mixing back-to-back starts with idle gaps
    for (int i = 0; i < 1000; i++) begin
      ro = 2'($urandom);
      rd = W'($urandom);
      rs = A'($urandom);
      run_op(ro, rd, rs, 1'b1, model(ro, rd, int'(rs)), "rnd");
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        chk("rnd_idle_done", 32'(done), 32'd0);
        chk("rnd_idle_result", 32'(result), 32'(model(ro, rd, int'(rs))));
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
